// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: drives an external registered full-adder stage
// one bit pair per step, LSB first, and assembles the sum with a carry-out.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PHW  = $clog2(LAT + 1);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(WIDTH - 1);
  localparam logic [PHW-1:0]  SAMPLE_PH = PHW'(LAT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [IDXW-1:0]  idx_q;
  logic [PHW-1:0]   phase_q;
  logic             in_ready_q, out_valid_q, cout_q;
  logic             fa_a_q, fa_b_q, fa_c_q;
  logic [WIDTH-1:0] res_d;

  // Sum bits arrive LSB first, so shift them in from the top.
  assign res_d = (res_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      phase_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      fa_a_q      <= 1'b0;
      fa_b_q      <= 1'b0;
      fa_c_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= op_a >> 1;
            b_q        <= op_b >> 1;
            fa_a_q     <= op_a[0];
            fa_b_q     <= op_b[0];
            fa_c_q     <= cin;
            idx_q      <= '0;
            phase_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (phase_q == SAMPLE_PH) begin
            res_q   <= res_d;
            phase_q <= '0;
            if (idx_q == LAST_IDX) begin
              cout_q      <= fa_carry;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              fa_a_q <= a_q[0];
              fa_b_q <= b_q[0];
              fa_c_q <= fa_carry;
              a_q    <= a_q >> 1;
              b_q    <= b_q >> 1;
              idx_q  <= idx_q + 1'b1;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign cout      = cout_q;
  assign fa_a      = fa_a_q;
  assign fa_b      = fa_b_q;
  assign fa_c      = fa_c_q;

endmodule
